// File: rtl/button_seq_gen.sv
// rtl/button_seq_gen.sv - button-press sequence recorder/player (optional looping via BUTTON_SEQ_LOOP_EN)
module button_seq_gen #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     sys_clkp,
    input  logic                     sys_clkn,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [3:0]               wr_code,
    input  logic [7:0]               wr_hold,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_mode,
    output logic [3:0]               button,
    output logic                     busy,
    output logic                     done,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    code_mem [DEPTH];
    logic [7:0]    hold_mem [DEPTH];
    logic [7:0]    hold_cnt, hold_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [IW-1:0] idx_n, load_idx;
    logic [CW-1:0] count_n, idx_next;
    logic [3:0]    button_n;
    logic          busy_n, done_n, full_n;
    logic          wr_ok, last_entry, step, load;
    logic          unused_pins;

    // The negative clock leg exists only for the board-level differential pair.
    assign unused_pins = &{1'b0, sys_clkn, loop_mode};

    assign wr_ok      = (state == IDLE) && wr_en && !full && !clear;
    assign idx_next   = {1'b0, idx} + 1'b1;
    assign last_entry = (idx_next >= count);

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        button_n   = 4'hF;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        count_n    = count;
        hold_cnt_n = hold_cnt;
        gap_cnt_n  = gap_cnt;
        step       = 1'b0;
        load       = 1'b0;
        load_idx   = '0;
        case (state)
            IDLE: begin
                if (clear) begin
                    count_n = '0;
                end else begin
                    if (wr_ok)
                        count_n = count + 1'b1;
                    if (start) begin
                        if (count != '0) begin
                            load = 1'b1;
                        end else begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (hold_cnt != 8'd0) begin
                    hold_cnt_n = hold_cnt - 8'd1;
                    button_n   = button;
                    busy_n     = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_n   = GAP;
                    gap_cnt_n = GW'(GAP_CYCLES - 1);
                    busy_n    = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gap_cnt != '0) begin
                    gap_cnt_n = gap_cnt - GW'(1);
                    busy_n    = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (step) begin
            if (!last_entry) begin
                load     = 1'b1;
                load_idx = idx_next[IW-1:0];
            end
`ifdef BUTTON_SEQ_LOOP_EN
            else if (loop_mode) begin
                load = 1'b1;
            end
`endif
            else begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end

        // Entering DRIVE always preloads code and hold so outputs stay registered.
        if (load) begin
            state_n    = DRIVE;
            idx_n      = load_idx;
            button_n   = code_mem[load_idx];
            hold_cnt_n = hold_mem[load_idx];
            busy_n     = 1'b1;
        end
    end

    assign full_n = (count_n == CW'(DEPTH));

    always_ff @(posedge sys_clkp or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            button   <= 4'hF;
            busy     <= 1'b0;
            done     <= 1'b0;
            full     <= 1'b0;
            count    <= '0;
            idx      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            button   <= button_n;
            busy     <= busy_n;
            done     <= done_n;
            full     <= full_n;
            count    <= count_n;
            idx      <= idx_n;
            hold_cnt <= hold_cnt_n;
            gap_cnt  <= gap_cnt_n;
        end
    end

    always_ff @(posedge sys_clkp) begin
        if (wr_ok) begin
            code_mem[count[IW-1:0]] <= wr_code;
            hold_mem[count[IW-1:0]] <= wr_hold;
        end
    end
endmodule

// File: tb/tb_button_seq_gen.sv
// tb/tb_button_seq_gen.sv - self-checking bench for button_seq_gen
module tb_button_seq_gen;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       clkn;
    logic       reset_n;
    logic       wr_en, clear, start, abort, loop_mode;
    logic [3:0] wr_code;
    logic [7:0] wr_hold;
    logic [3:0] button;
    logic       busy, done, full;
    logic [4:0] count;
    logic [3:0] idx;

    int n_checks = 0;
    int n_fails  = 0;

    logic [3:0] m_code [DEPTH];
    logic [7:0] m_hold [DEPTH];
    int         m_count = 0;

    typedef struct {
        logic [3:0] button;
        logic       busy;
        logic       done;
        int         idx;
    } exp_t;

    typedef struct {
        logic       wr_en;
        logic [3:0] code;
        logic [7:0] hold;
        logic       clear;
        logic [4:0] exp_count;
        logic       exp_full;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;
    assign clkn = ~clk;

    button_seq_gen #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .sys_clkp (clk),
        .sys_clkn (clkn),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_code  (wr_code),
        .wr_hold  (wr_hold),
        .clear    (clear),
        .start    (start),
        .abort    (abort),
        .loop_mode(loop_mode),
        .button   (button),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .count    (count),
        .idx      (idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_entry(input logic [3:0] code, input logic [7:0] hold);
        wr_en = 1'b1; wr_code = code; wr_hold = hold;
        tick();
        wr_en = 1'b0;
        if (m_count < DEPTH) begin
            m_code[m_count] = code;
            m_hold[m_count] = hold;
            m_count++;
        end
        chk("write_count", 32'(count), 32'(m_count));
    endtask

    task automatic clear_all();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_count = 0;
        chk("clear_count", 32'(count), 32'd0);
    endtask

    // Builds the expected per-cycle output stream from the model, then plays it.
    task automatic play(input string tag, input int abort_entry, input bit lp, input bit poke);
        exp_t q[$];
        exp_t r;
        int   ab = -1;
        int   last;
        int   n = 0;
        int   aidx;
        for (int i = 0; i < m_count; i++) begin
            if (i == abort_entry) ab = q.size();
            for (int c = 0; c <= int'(m_hold[i]); c++) q.push_back('{m_code[i], 1'b1, 1'b0, i});
            for (int g = 0; g < GAP; g++) q.push_back('{4'hF, 1'b1, 1'b0, i});
        end
        last = (m_count == 0) ? 0 : m_count - 1;
`ifdef BUTTON_SEQ_LOOP_EN
        if (lp && m_count > 0) begin
            ab = q.size();
            q.push_back('{m_code[0], 1'b1, 1'b0, 0});
        end
`endif
        if (ab >= 0) begin
            while (q.size() > ab + 1) void'(q.pop_back());
            aidx = q[ab].idx;
            q.push_back('{4'hF, 1'b0, 1'b0, aidx});
            q.push_back('{4'hF, 1'b0, 1'b0, aidx});
        end else begin
            q.push_back('{4'hF, 1'b0, 1'b1, last});
            q.push_back('{4'hF, 1'b0, 1'b0, last});
        end

        loop_mode = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (q.size() > 0) begin
            r = q.pop_front();
            chk($sformatf("%s_cyc%0d", tag, n), {22'd0, button, busy, done, idx},
                {22'd0, r.button, r.busy, r.done, 4'(r.idx)});
            abort = (n == ab);
            if (poke && n == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_code = 4'h0; wr_hold = 8'h0;
            end
            tick();
            abort = 1'b0; start = 1'b0; wr_en = 1'b0;
            n++;
        end
        loop_mode = 1'b0;
        chk({tag, "_count_kept"}, 32'(count), 32'(m_count));
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; clear = 1'b0; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
        wr_code = 4'h0; wr_hold = 8'h0;

        for (int i = 0; i < 17; i++) begin
            vecs[i] = '{1'b1, 4'(i), 8'(i), 1'b0, (i < 16) ? 5'(i + 1) : 5'd16, (i >= 15)};
        end
        vecs[17] = '{1'b1, 4'h5, 8'h5, 1'b1, 5'd0, 1'b0};

        #12;
        chk("reset_outputs", {20'd0, button, busy, done, full, count, idx},
            {20'd0, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        play("empty", -1, 1'b0, 1'b0);

        write_entry(4'b1011, 8'd3);
        play("single", -1, 1'b0, 1'b0);
        clear_all();

        write_entry(4'b1101, 8'd1);
        write_entry(4'b1011, 8'd1);
        write_entry(4'b0111, 8'd1);
        write_entry(4'b0001, 8'd1);
        play("multi", -1, 1'b0, 1'b1);
        play("replay_abort", 2, 1'b0, 1'b0);
        clear_all();

        for (int i = 0; i < 18; i++) begin
            wr_en = vecs[i].wr_en; wr_code = vecs[i].code;
            wr_hold = vecs[i].hold; clear = vecs[i].clear;
            tick();
            wr_en = 1'b0; clear = 1'b0;
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
        end
        m_count = 0;

        write_entry(4'b1110, 8'd0);
        write_entry(4'b0110, 8'd2);
        play("loop", -1, 1'b1, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {20'd0, button, busy, done, full, count, idx},
            {20'd0, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset%0d", i), {29'd0, button == 4'hF, busy, done}, {29'd0, 1'b1, 1'b0, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/button_seq_gen.md
BUTTON_SEQ_GEN -- requirements
Module: button_seq_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of sequence entries.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles between entries (0 = no gap).
REQ-003 SHALL have port sys_clkp  input  1  positive leg of the single differential system clock; all logic uses its rising edge.
REQ-004 SHALL have port sys_clkn  input  1  negative leg of the same clock; it is not used by the logic.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  appends {wr_code, wr_hold} to the sequence.
REQ-007 SHALL have port wr_code  input  4  active-low button code to play.
REQ-008 SHALL have port wr_hold  input  8  hold length; the code is driven for wr_hold+1 cycles.
REQ-009 SHALL have port clear  input  1  empties the sequence.
REQ-010 SHALL have port start  input  1  begins playback.
REQ-011 SHALL have port abort  input  1  stops playback immediately.
REQ-012 SHALL have port loop_mode  input  1  requests repeat playback (see Configuration).
REQ-013 SHALL have port button  output  4  active-low button code driven to the consuming FSM.
REQ-014 SHALL have port busy  output  1  high while playback is running.
REQ-015 SHALL have port done  output  1  one-cycle pulse at the end of playback.
REQ-016 SHALL have port full  output  1  high when count == DEPTH.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-018 SHALL have port idx  output  $clog2(DEPTH)  index of the entry currently playing.

Function
REQ-019 SHALL implement the states IDLE, DRIVE, GAP and DONE.
REQ-020 SHALL, in IDLE, drive button = 4'b1111 and busy = 0.
REQ-021 SHALL, in IDLE with wr_en=1 and full=0, store the entry at address count and increment count on the next edge.
REQ-022 SHALL ignore wr_en when full=1 or when not in IDLE; count and storage are unchanged.
REQ-023 SHALL, in IDLE with clear=1, set count to 0 on the next edge; if wr_en is also high, clear wins and nothing is written.
REQ-024 SHALL, in IDLE with start=1 and count>0, enter DRIVE on the next edge with idx=0, button=code[0] and busy=1.
REQ-025 SHALL, in IDLE with start=1 and count=0, enter DONE directly; button stays 4'b1111.
REQ-026 SHALL give start no effect when clear=1 in the same cycle.
REQ-027 SHALL hold button = code[idx] in DRIVE for exactly hold[idx]+1 cycles, so hold=0 gives 1 cycle and hold=255 gives 256 cycles.
REQ-028 SHALL, after DRIVE, enter GAP and drive 4'b1111 for GAP_CYCLES cycles; when GAP_CYCLES=0, GAP is skipped.
REQ-029 SHALL, after GAP, continue with entry idx+1 in DRIVE if idx+1 < count; otherwise it enters DONE.
REQ-030 SHALL, in DONE, assert done=1 for one cycle with busy=0 and button=4'b1111, then return to IDLE.
REQ-031 SHALL, on abort=1 in DRIVE or GAP, return to IDLE on the next edge with button=4'b1111 and no done pulse; abort outranks start.
REQ-032 SHALL ignore start while busy.
REQ-033 SHALL retain stored entries after playback so that the same sequence can be replayed.
REQ-034 SHALL register all outputs: button, busy, done, full, count and idx.

Reset
REQ-035 SHALL, while reset_n=0, immediately force state=IDLE, button=4'b1111, busy=0, done=0, count=0, idx=0 and full=0.
REQ-036 SHALL, when reset is asserted during playback, abandon the playback without a done pulse; entry storage contents are don't-care.

Configuration
REQ-037 SHALL, with macro BUTTON_SEQ_LOOP_EN defined, make the step after the last entry's GAP wrap to idx=0 in DRIVE while loop_mode=1 (sampled at that point), with no done pulse; abort exits.
REQ-038 SHALL, without BUTTON_SEQ_LOOP_EN, keep the loop_mode port present but ignore it, always ending in DONE.

Verification
REQ-039 SHALL cover single entry: write {4'b1011, 3}, start -> button=1011 for 4 cycles, 1111 for 2 cycles, then done pulse 1 cycle.
REQ-040 SHALL cover the multi-entry sequence 1101 / 1011 / 0111 / 0001 with hold=1 each -> each code appears 2 cycles with 2-cycle gaps, in order, idx = 0..3.
REQ-041 SHALL cover fill: write 17 entries -> full=1 after the 16th, count=16, and the 17th is ignored; clear with wr_en -> count=0.
REQ-042 SHALL cover abort: abort during the third entry -> button=1111 and busy=0 the next cycle, done stays 0.
REQ-043 SHALL cover empty start: start with count=0 -> done pulse 1 cycle later, button stays 1111.
REQ-044 SHALL cover loop: with BUTTON_SEQ_LOOP_EN defined, loop_mode=1 and 2 entries -> after entry 1's gap, idx=0 replays; without the macro -> done pulse.
